// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared constants, state encoding and helpers for mux_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational rotating-priority picker; scan starts after last_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] w_win;
    logic [SEL_W-1:0] w_pos;

    // Offset N_REQ wraps back to last_ptr itself, so it is scanned last.
    always_comb begin
        w_win = '0;
        w_pos = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_pos = last_ptr + SEL_W'(i);
            if (req[w_pos] && (w_win == '0)) begin
                w_win[w_pos] = 1'b1;
            end
        end
    end

    assign valid = |req;
    assign idx   = onehot_to_idx(w_win);

endmodule
`default_nettype wire

// File: rtl/mux_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_bus_arbiter
// Brief    : Round-robin 4-way bus arbiter with hold timeout and mux select.
// Revision : 1.0 - initial release
// ============================================================================
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q,    state_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
    logic             timeout_q,  timeout_d;

    logic [N_REQ-1:0] w_pick_req;
    logic [SEL_W-1:0] w_pick_ptr;
    logic             w_pick_valid;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_rel_done;
    logic             w_rel_drop;
    logic             w_rel_hold;
    logic             w_release;

    // While owned, the current owner becomes the rotation pointer so a
    // release hands over in the same cycle without an idle bubble.
    always_comb begin
        w_rel_done = done[sel_q];
        w_rel_drop = ~req[sel_q];
        w_rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == c_hold_last);
        w_release  = (state_q == OWNED) && (w_rel_done || w_rel_drop || w_rel_hold);
        w_pick_ptr = (state_q == OWNED) ? sel_q : last_ptr_q;
        w_pick_req = req;
        if ((state_q == OWNED) && w_rel_done) begin
            w_pick_req[sel_q] = 1'b0;
        end
    end

    rr_pick4 u_pick (
        .req      (w_pick_req),
        .last_ptr (w_pick_ptr),
        .valid    (w_pick_valid),
        .idx      (w_pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        last_ptr_d = last_ptr_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d             = OWNED;
                    gnt_d               = '0;
                    gnt_d[w_pick_idx]   = 1'b1;
                    sel_d               = w_pick_idx;
                    hold_cnt_d          = '0;
                end
            end
            OWNED: begin
                if (w_release) begin
                    last_ptr_d = sel_q;
                    // A simultaneous done or req drop counts as a normal release.
                    timeout_d  = w_rel_hold & ~w_rel_done & ~w_rel_drop;
                    hold_cnt_d = '0;
                    if (w_pick_valid) begin
                        gnt_d             = '0;
                        gnt_d[w_pick_idx] = 1'b1;
                        sel_d             = w_pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != '1)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            hold_cnt_q <= '0;
            last_ptr_q <= SEL_W'(N_REQ - 1);
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            last_ptr_q <= last_ptr_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire
